// File: rtl/game_pkg.sv
// Shared types for the chess turn scheduler: FSM state encoding, side colours and square type.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitMove = 3'd1,
    StCommit   = 3'd2,
    StSwap     = 3'd3,
    StGameOver = 3'd4
  } sched_state_e;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  // {row[5:3], col[2:0]}
  typedef logic [5:0] square_t;

endpackage

// File: rtl/chess_timer.sv
// Per-side countdown clock: loads Init, decrements on enabled ticks without
// going below zero, and adds a saturating increment on request.
module chess_timer #(
  parameter int unsigned TIMER_W = 10,
  parameter int unsigned Init    = 600,
  parameter int unsigned Inc     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic               tick,
  input  logic               inc,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  logic [TIMER_W-1:0] count_d, count_q;
  logic [TIMER_W:0]   sum;

  always_comb begin
    sum     = {1'b0, count_q} + (TIMER_W + 1)'(Inc);
    count_d = count_q;
    if (load) begin
      count_d = TIMER_W'(Init);
    end else if (en && tick) begin
      if (count_q != '0) count_d = count_q - 1'b1;
    end else if (inc) begin
      count_d = sum[TIMER_W] ? '1 : sum[TIMER_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= TIMER_W'(Init);
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/turn_scheduler.sv
// Chess turn scheduler: routes local/remote moves to the board updater and runs both clocks.
// Optional macro TURN_INCREMENT_EN adds INC_S seconds to the mover's clock in SWAP.
module turn_scheduler
  import game_pkg::*;
#(
  parameter int unsigned TIME_LIMIT_S = 600,
  parameter int unsigned TIMER_W      = 10,
  parameter int unsigned INC_S        = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               local_is_white,
  input  logic               sec_tick,
  input  logic               loc_req,
  input  logic [5:0]         loc_from,
  input  logic [5:0]         loc_to,
  input  logic               rem_req,
  input  logic [5:0]         rem_from,
  input  logic [5:0]         rem_to,
  input  logic               mv_ack,
  output logic               mv_valid,
  output logic [5:0]         mv_from,
  output logic [5:0]         mv_to,
  output logic               side_to_move,
  output logic               your_turn,
  output logic               req_reject,
  output logic [TIMER_W-1:0] time_white,
  output logic [TIMER_W-1:0] time_black,
  output logic               game_over,
  output logic               loser
);

  sched_state_e state_d, state_q;
  logic    side_d, side_q, local_d, local_q;
  logic    mv_valid_d, mv_valid_q, your_turn_d, your_turn_q;
  logic    reject_d, reject_q, game_over_d, game_over_q, loser_d, loser_q;
  square_t mv_from_d, mv_from_q, mv_to_d, mv_to_q;

  logic    running, load, timeout, mover_last;
  logic    en_w, en_b, inc_w, inc_b, zero_w, zero_b;
  logic    elig_local, e_req, o_req;
  square_t e_from, e_to;

  assign running = (state_q == StWaitMove) || (state_q == StCommit);
  assign load    = start && ((state_q == StIdle) || (state_q == StGameOver));
  assign en_w    = running && (side_q == COLOR_WHITE);
  assign en_b    = running && (side_q == COLOR_BLACK);

`ifdef TURN_INCREMENT_EN
  assign inc_w = (state_q == StSwap) && (side_q == COLOR_WHITE);
  assign inc_b = (state_q == StSwap) && (side_q == COLOR_BLACK);
`else
  assign inc_w = 1'b0;
  assign inc_b = 1'b0;
`endif

  chess_timer #(.TIMER_W(TIMER_W), .Init(TIME_LIMIT_S), .Inc(INC_S)) u_timer_white (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .en    (en_w),
    .tick  (sec_tick),
    .inc   (inc_w),
    .count (time_white),
    .zero  (zero_w)
  );

  chess_timer #(.TIMER_W(TIMER_W), .Init(TIME_LIMIT_S), .Inc(INC_S)) u_timer_black (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .en    (en_b),
    .tick  (sec_tick),
    .inc   (inc_b),
    .count (time_black),
    .zero  (zero_b)
  );

  // A tick on a clock reading 1 (or already 0) ends the game for the mover.
  assign mover_last = side_q ? (zero_b || (time_black == TIMER_W'(1)))
                             : (zero_w || (time_white == TIMER_W'(1)));
  assign timeout    = running && sec_tick && mover_last;

  assign elig_local = (side_q == local_q);
  assign e_req      = elig_local ? loc_req  : rem_req;
  assign o_req      = elig_local ? rem_req  : loc_req;
  assign e_from     = elig_local ? loc_from : rem_from;
  assign e_to       = elig_local ? loc_to   : rem_to;

  always_comb begin
    state_d     = state_q;
    side_d      = side_q;
    local_d     = local_q;
    mv_valid_d  = mv_valid_q;
    mv_from_d   = mv_from_q;
    mv_to_d     = mv_to_q;
    reject_d    = 1'b0;
    game_over_d = game_over_q;
    loser_d     = loser_q;
    your_turn_d = (state_q == StWaitMove) && (side_q == local_q);
    case (state_q)
      StIdle, StGameOver: begin
        reject_d = (state_q == StGameOver) && (loc_req || rem_req);
        if (start) begin
          state_d     = StWaitMove;
          side_d      = COLOR_WHITE;
          local_d     = local_is_white ? COLOR_WHITE : COLOR_BLACK;
          mv_valid_d  = 1'b0;
          game_over_d = 1'b0;
          loser_d     = 1'b0;
        end
      end
      StWaitMove: begin
        if (timeout) begin
          state_d     = StGameOver;
          game_over_d = 1'b1;
          loser_d     = side_q;
          reject_d    = loc_req || rem_req;
        end else begin
          if (e_req && (e_from != e_to)) begin
            state_d    = StCommit;
            mv_valid_d = 1'b1;
            mv_from_d  = e_from;
            mv_to_d    = e_to;
          end
          reject_d = o_req || (e_req && (e_from == e_to));
        end
      end
      StCommit: begin
        reject_d = loc_req || rem_req;
        if (timeout) begin
          state_d     = StGameOver;
          game_over_d = 1'b1;
          loser_d     = side_q;
          mv_valid_d  = 1'b0;
        end else if (mv_ack) begin
          state_d    = StSwap;
          mv_valid_d = 1'b0;
        end
      end
      StSwap: begin
        reject_d = loc_req || rem_req;
        side_d   = ~side_q;
        state_d  = StWaitMove;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      side_q      <= COLOR_WHITE;
      local_q     <= COLOR_WHITE;
      mv_valid_q  <= 1'b0;
      mv_from_q   <= '0;
      mv_to_q     <= '0;
      your_turn_q <= 1'b0;
      reject_q    <= 1'b0;
      game_over_q <= 1'b0;
      loser_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      side_q      <= side_d;
      local_q     <= local_d;
      mv_valid_q  <= mv_valid_d;
      mv_from_q   <= mv_from_d;
      mv_to_q     <= mv_to_d;
      your_turn_q <= your_turn_d;
      reject_q    <= reject_d;
      game_over_q <= game_over_d;
      loser_q     <= loser_d;
    end
  end

  assign mv_valid     = mv_valid_q;
  assign mv_from      = mv_from_q;
  assign mv_to        = mv_to_q;
  assign side_to_move = side_q;
  assign your_turn    = your_turn_q;
  assign req_reject   = reject_q;
  assign game_over    = game_over_q;
  assign loser        = loser_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed table-driven bench for turn_scheduler (TIME_LIMIT_S = 10, INC_S = 5).
module tb_turn_scheduler;

`ifdef TURN_INCREMENT_EN
  localparam int Inc = 5;
`else
  localparam int Inc = 0;
`endif
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic       clk = 1'b0;
  logic       rst, start, local_is_white, sec_tick, loc_req, rem_req, mv_ack;
  logic [5:0] loc_from, loc_to, rem_from, rem_to;
  logic       mv_valid, side_to_move, your_turn, req_reject, game_over, loser;
  logic [5:0] mv_from, mv_to;
  logic [9:0] time_white, time_black;

  int passed = 0;
  int total  = 0;

  turn_scheduler #(.TIME_LIMIT_S(10), .TIMER_W(10), .INC_S(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .local_is_white (local_is_white),
    .sec_tick       (sec_tick),
    .loc_req        (loc_req),
    .loc_from       (loc_from),
    .loc_to         (loc_to),
    .rem_req        (rem_req),
    .rem_from       (rem_from),
    .rem_to         (rem_to),
    .mv_ack         (mv_ack),
    .mv_valid       (mv_valid),
    .mv_from        (mv_from),
    .mv_to          (mv_to),
    .side_to_move   (side_to_move),
    .your_turn      (your_turn),
    .req_reject     (req_reject),
    .time_white     (time_white),
    .time_black     (time_black),
    .game_over      (game_over),
    .loser          (loser)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       start, liw, tick, lreq;
    logic [5:0] lf, lt;
    logic       rreq;
    logic [5:0] rf, rt;
    logic       ack, e_valid;
    logic [5:0] e_from, e_to;
    logic       e_side, e_rej, e_yt, e_go;
    int         e_tw, e_tb;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [5:0] f, input logic [5:0] t,
                         input logic s, input logic rj, input logic yt, input logic go,
                         input int tw, input int tb);
    chk({tag, ".mv_valid"}, int'(mv_valid), int'(v));
    chk({tag, ".mv_from"}, int'(mv_from), int'(f));
    chk({tag, ".mv_to"}, int'(mv_to), int'(t));
    chk({tag, ".side"}, int'(side_to_move), int'(s));
    chk({tag, ".reject"}, int'(req_reject), int'(rj));
    chk({tag, ".your_turn"}, int'(your_turn), int'(yt));
    chk({tag, ".game_over"}, int'(game_over), int'(go));
    chk({tag, ".time_white"}, int'(time_white), tw);
    chk({tag, ".time_black"}, int'(time_black), tb);
  endtask

  task automatic clear_in();
    start = 0; sec_tick = 0; loc_req = 0; rem_req = 0; mv_ack = 0;
    loc_from = '0; loc_to = '0; rem_from = '0; rem_to = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  initial begin
    rst = 1; local_is_white = 0;
    clear_in();
    //          st liw tk lrq lf     lt     rrq rf     rt     ack | v  from   to     s  rej yt go tw         tb
    vecs[0]  = '{T, T, F, F, 6'o00, 6'o00, F, 6'o00, 6'o00, F,   F, 6'o00, 6'o00, F, F, F, F, 10,        10};
    vecs[1]  = '{F, T, F, F, 6'o00, 6'o00, F, 6'o00, 6'o00, F,   F, 6'o00, 6'o00, F, F, T, F, 10,        10};
    vecs[2]  = '{F, T, T, F, 6'o00, 6'o00, F, 6'o00, 6'o00, F,   F, 6'o00, 6'o00, F, F, T, F, 9,         10};
    vecs[3]  = '{F, T, F, T, 6'o14, 6'o34, F, 6'o00, 6'o00, F,   T, 6'o14, 6'o34, F, F, T, F, 9,         10};
    vecs[4]  = '{F, T, F, F, 6'o00, 6'o00, F, 6'o00, 6'o00, F,   T, 6'o14, 6'o34, F, F, F, F, 9,         10};
    vecs[5]  = '{F, T, F, F, 6'o00, 6'o00, F, 6'o00, 6'o00, T,   F, 6'o14, 6'o34, F, F, F, F, 9,         10};
    vecs[6]  = '{F, T, F, F, 6'o00, 6'o00, F, 6'o00, 6'o00, F,   F, 6'o14, 6'o34, T, F, F, F, 9+Inc,     10};
    vecs[7]  = '{F, T, F, T, 6'o01, 6'o02, F, 6'o00, 6'o00, F,   F, 6'o14, 6'o34, T, T, F, F, 9+Inc,     10};
    vecs[8]  = '{F, T, F, F, 6'o00, 6'o00, T, 6'o64, 6'o44, F,   T, 6'o64, 6'o44, T, F, F, F, 9+Inc,     10};
    vecs[9]  = '{F, T, F, F, 6'o00, 6'o00, F, 6'o00, 6'o00, T,   F, 6'o64, 6'o44, T, F, F, F, 9+Inc,     10};
    vecs[10] = '{F, T, F, F, 6'o00, 6'o00, F, 6'o00, 6'o00, F,   F, 6'o64, 6'o44, F, F, F, F, 9+Inc,     10+Inc};
    vecs[11] = '{F, T, F, T, 6'o12, 6'o12, F, 6'o00, 6'o00, F,   F, 6'o64, 6'o44, F, T, T, F, 9+Inc,     10+Inc};
    vecs[12] = '{F, T, F, T, 6'o10, 6'o20, T, 6'o60, 6'o50, F,   T, 6'o10, 6'o20, F, T, T, F, 9+Inc,     10+Inc};
    vecs[13] = '{F, T, F, F, 6'o00, 6'o00, F, 6'o00, 6'o00, T,   F, 6'o10, 6'o20, F, F, F, F, 9+Inc,     10+Inc};
    vecs[14] = '{F, T, F, F, 6'o00, 6'o00, F, 6'o00, 6'o00, F,   F, 6'o10, 6'o20, T, F, F, F, 9+2*Inc,   10+Inc};
    vecs[15] = '{F, T, F, F, 6'o00, 6'o00, T, 6'o63, 6'o43, F,   T, 6'o63, 6'o43, T, F, F, F, 9+2*Inc,   10+Inc};
    vecs[16] = '{F, T, F, F, 6'o00, 6'o00, F, 6'o00, 6'o00, T,   F, 6'o63, 6'o43, T, F, F, F, 9+2*Inc,   10+Inc};
    vecs[17] = '{F, T, F, F, 6'o00, 6'o00, F, 6'o00, 6'o00, F,   F, 6'o63, 6'o43, F, F, F, F, 9+2*Inc,   10+2*Inc};

    repeat (2) cycle();
    chk_all("reset", F, 6'o00, 6'o00, F, F, F, F, 10, 10);
    chk("reset.loser", int'(loser), 0);
    rst = 0;

    for (int i = 0; i < 18; i++) begin
      start = vecs[i].start; local_is_white = vecs[i].liw; sec_tick = vecs[i].tick;
      loc_req = vecs[i].lreq; loc_from = vecs[i].lf; loc_to = vecs[i].lt;
      rem_req = vecs[i].rreq; rem_from = vecs[i].rf; rem_to = vecs[i].rt;
      mv_ack = vecs[i].ack;
      cycle();
      chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_from, vecs[i].e_to,
              vecs[i].e_side, vecs[i].e_rej, vecs[i].e_yt, vecs[i].e_go, vecs[i].e_tw,
              vecs[i].e_tb);
    end

    // Run white's clock down to 1, commit a move, then ack together with the final tick.
    cycle();
    chk("pre_timeout.your_turn", int'(your_turn), 1);
    for (int k = 0; k < 9 + 2 * Inc - 1; k++) begin
      sec_tick = 1;
      cycle();
    end
    chk("countdown.time_white", int'(time_white), 1);
    loc_req = 1; loc_from = 6'o11; loc_to = 6'o31;
    cycle();
    chk_all("late_move", T, 6'o11, 6'o31, F, F, T, F, 1, 10 + 2 * Inc);
    sec_tick = 1; mv_ack = 1;
    cycle();
    chk_all("timeout", F, 6'o11, 6'o31, F, F, F, T, 0, 10 + 2 * Inc);
    chk("timeout.loser", int'(loser), 0);
    loc_req = 1; loc_from = 6'o01; loc_to = 6'o02; sec_tick = 1;
    cycle();
    chk_all("over_req", F, 6'o11, 6'o31, F, T, F, T, 0, 10 + 2 * Inc);

    // Restart with local playing black: remote is eligible for white's move.
    start = 1; local_is_white = 0;
    cycle();
    chk_all("restart", F, 6'o11, 6'o31, F, F, F, F, 10, 10);
    chk("restart.loser", int'(loser), 0);
    rem_req = 1; rem_from = 6'o06; rem_to = 6'o26;
    cycle();
    chk_all("remote_white", T, 6'o06, 6'o26, F, F, F, F, 10, 10);

    // Reset mid-commit withdraws the move.
    rst = 1;
    cycle();
    chk_all("mid_reset", F, 6'o00, 6'o00, F, F, F, F, 10, 10);
    rst = 0;
    cycle();
    chk_all("post_reset", F, 6'o00, 6'o00, F, F, F, F, 10, 10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
